tile_plane_fetcher: RTL

Parametrised successor to the background fetcher: fetches tile-map entries and N-bitplane tile rows from VRAM on T-cycle enables, and decodes them into pixels. Pixels go into an internal pixel FIFO that the mixer pops one pixel per clock. Added behaviour:
- Configurable bitplane count.
- Built-in FIFO with occupancy.
- Fine-scroll discard at line start.
- Window restart with FIFO flush.
- Explicit pause handshake for sprite fetches.

---
 rtl/tile_plane_fetcher.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/tile_plane_fetcher.sv
// tile_plane_fetcher: fetches map entries and PLANES-bitplane tile rows from
// VRAM on T-cycle enables, decodes each row into 8 pixels and pushes them
// into an internal pixel FIFO that the mixer pops one pixel per clock.
// Ports:
//   clk_in / rst_in                  clock, async active-low reset
//   tclk_in                          T-cycle enable gating all fetch FSM moves
//   line_start_in, window_trigger_in scanline / window restart events
//   fine_x_in, coarse_x_in, row_in   background scroll position
//   win_row_in, *_base_in            window row, map and tile base addresses
//   signed_mode_in                   signed tile numbers around tile_base_in
//   addr_out, addr_valid_out         registered memory request
//   data_in, data_valid_in           memory read data
//   pause_in, pause_ack_out          sprite-fetch pause handshake
//   pop_in, pixel_out, pixel_valid_out, fifo_count_out  pixel FIFO side
module tile_plane_fetcher #(
  parameter int unsigned PLANES     = 2,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          tclk_in,
  input  logic                          line_start_in,
  input  logic                          window_trigger_in,
  input  logic [2:0]                    fine_x_in,
  input  logic [4:0]                    coarse_x_in,
  input  logic [7:0]                    row_in,
  input  logic [7:0]                    win_row_in,
  input  logic [15:0]                   map_base_in,
  input  logic [15:0]                   win_map_base_in,
  input  logic [15:0]                   tile_base_in,
  input  logic                          signed_mode_in,
  output logic [15:0]                   addr_out,
  output logic                          addr_valid_out,
  input  logic [7:0]                    data_in,
  input  logic                          data_valid_in,
  input  logic                          pause_in,
  output logic                          pause_ack_out,
  input  logic                          pop_in,
  output logic [PLANES-1:0]             pixel_out,
  output logic                          pixel_valid_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0] STRIDE = 16'(PLANES * 8);
  localparam logic [15:0] PL16   = 16'(PLANES);

  typedef enum logic [2:0] {S_IDLE, S_TILE_NUM, S_PLANE, S_PUSH, S_PAUSE} state_t;

  state_t            r_state;
  logic              r_cap;        // 0 = request step, 1 = capture step
  logic [1:0]        r_p;
  logic [4:0]        r_tc;
  logic              r_win;
  logic [2:0]        r_discard;
  logic [7:0]        r_tile_num;
  logic [7:0]        r_plane [PLANES];
  logic              r_push_pend;
  logic [PW-1:0]     r_wp;
  logic [PW-1:0]     r_rp;
  logic [CW-1:0]     r_count;
  logic [PLANES-1:0] r_mem [FIFO_DEPTH];

  logic [7:0]        w_rd_byte;
  logic              w_last_p;
  logic [2:0]        w_row_lo;
  logic [15:0]       w_tn_ext;
  logic [15:0]       w_map_addr;
  logic [15:0]       w_tile_addr;
  logic              w_room;
  logic              w_evt;
  logic              w_flush;
  logic              w_push_cond;
  logic              w_do_push;
  logic              w_pop;
  logic [CW-1:0]     w_n_push;
  logic [7:0]        w_src [PLANES];
  logic [PLANES-1:0] w_sh  [8];

  assign w_rd_byte = data_valid_in ? data_in : 8'hFF;
  assign w_last_p  = (r_p == 2'(PLANES - 1));
  assign w_row_lo  = r_win ? win_row_in[2:0] : row_in[2:0];
  assign w_tn_ext  = signed_mode_in ? {{8{r_tile_num[7]}}, r_tile_num} : {8'h00, r_tile_num};

  // Map column wraps within the 32-entry row.
  assign w_map_addr = r_win
    ? win_map_base_in + {3'd0, win_row_in[7:3], 5'd0} + {11'd0, r_tc}
    : map_base_in + {3'd0, row_in[7:3], 5'd0} + {11'd0, 5'(coarse_x_in + r_tc)};

  assign w_tile_addr = tile_base_in + w_tn_ext * STRIDE
                     + {13'd0, w_row_lo} * PL16 + {14'd0, r_p};

  // Room check uses the pre-pop count.
  assign w_room      = (r_count <= CW'(FIFO_DEPTH - 8));
  assign w_evt       = line_start_in || (window_trigger_in && (r_state != S_IDLE));
  assign w_flush     = tclk_in && w_evt;
  assign w_push_cond = ((r_state == S_PLANE) && r_cap && w_last_p) || (r_state == S_PUSH);
  assign w_do_push   = tclk_in && !w_evt && w_push_cond && w_room;
  assign w_pop       = pop_in && (r_count != '0);
  assign w_n_push    = CW'(4'd8 - {1'b0, r_discard});

  // Decode the row; the last plane comes straight from the bus on the capture step.
  always_comb begin
    logic [2:0] idx;
    idx = '0;
    for (int j = 0; j < PLANES; j++) w_src[j] = r_plane[j];
    if (r_state != S_PUSH) w_src[PLANES-1] = w_rd_byte;
    for (int i = 0; i < 8; i++) begin
      idx = 3'd7 - 3'(3'(i) + r_discard);
      for (int j = 0; j < PLANES; j++) w_sh[i][j] = w_src[j][idx];
    end
  end

  // Pixel FIFO storage: up to 8 entries written per push.
  always_ff @(posedge clk_in) begin
    if (w_do_push) begin
      for (int k = 0; k < 8; k++) begin
        if (CW'(k) < w_n_push) r_mem[r_wp + PW'(k)] <= w_sh[k];
      end
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)     r_rp <= r_rp + PW'(1);
      if (w_do_push) r_wp <= r_wp + PW'(w_n_push);
      r_count <= r_count - CW'(w_pop) + (w_do_push ? w_n_push : CW'(0));
    end
  end

  assign fifo_count_out  = r_count;
  assign pixel_valid_out = (r_count != '0);
  assign pixel_out       = pixel_valid_out ? r_mem[r_rp] : '0;

  // Fetch FSM with registered request and pause outputs.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= S_IDLE;
      r_cap          <= 1'b0;
      r_p            <= '0;
      r_tc           <= '0;
      r_win          <= 1'b0;
      r_discard      <= '0;
      r_tile_num     <= '0;
      r_push_pend    <= 1'b0;
      addr_out       <= '0;
      addr_valid_out <= 1'b0;
      pause_ack_out  <= 1'b0;
      for (int j = 0; j < PLANES; j++) r_plane[j] <= '0;
    end else if (tclk_in) begin
      if (w_evt) begin
        r_state        <= S_TILE_NUM;
        r_cap          <= 1'b0;
        r_tc           <= '0;
        r_win          <= !line_start_in;
        r_discard      <= line_start_in ? fine_x_in : 3'd0;
        r_push_pend    <= 1'b0;
        addr_valid_out <= 1'b0;
        pause_ack_out  <= 1'b0;
      end else begin
        case (r_state)
          S_TILE_NUM: begin
            if (!r_cap) begin
              addr_out       <= w_map_addr;
              addr_valid_out <= 1'b1;
              r_cap          <= 1'b1;
            end else begin
              r_tile_num     <= w_rd_byte;
              addr_valid_out <= 1'b0;
              r_cap          <= 1'b0;
              r_p            <= '0;
              r_state        <= S_PLANE;
            end
          end
          S_PLANE: begin
            if (!r_cap) begin
              addr_out       <= w_tile_addr;
              addr_valid_out <= 1'b1;
              r_cap          <= 1'b1;
            end else begin
              addr_valid_out <= 1'b0;
              r_cap          <= 1'b0;
              for (int j = 0; j < PLANES; j++) begin
                if (2'(j) == r_p) r_plane[j] <= w_rd_byte;
              end
              if (!w_last_p) begin
                r_p <= r_p + 2'd1;
              end else if (w_room) begin
                r_tc          <= r_tc + 5'd1;
                r_discard     <= '0;
                r_state       <= pause_in ? S_PAUSE : S_TILE_NUM;
                pause_ack_out <= pause_in;
              end else begin
                r_push_pend <= 1'b1;
                r_state     <= S_PUSH;
              end
            end
          end
          S_PUSH: begin
            if (w_room) begin
              r_tc          <= r_tc + 5'd1;
              r_discard     <= '0;
              r_push_pend   <= 1'b0;
              r_state       <= pause_in ? S_PAUSE : S_TILE_NUM;
              pause_ack_out <= pause_in;
            end else if (pause_in) begin
              r_state       <= S_PAUSE;
              pause_ack_out <= 1'b1;
            end
          end
          S_PAUSE: begin
            // A push deferred for lack of room is finished before fetching on.
            if (!pause_in) begin
              pause_ack_out <= 1'b0;
              r_cap         <= 1'b0;
              r_state       <= r_push_pend ? S_PUSH : S_TILE_NUM;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
